ysyx_23060187_wbu: RTL and testbench

YSYX_23060187_WBU -- requirements
Module: ysyx_23060187_wbu

---
 rtl/ysyx_23060187_pkg.sv | 17 +
 rtl/ysyx_23060187_wbu_if.sv | 35 +++
 rtl/ysyx_23060187_load_ext.sv | 44 ++++
 rtl/ysyx_23060187_wbu.sv | 129 ++++++++++++
 tb/tb_ysyx_23060187_wbu.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060187_pkg.sv
// rtl/ysyx_23060187_pkg.sv - shared WBU state encoding and load funct3 codes
// Ports: none (package).
package ysyx_23060187_pkg;

    typedef enum logic [1:0] {
        WBU_IDLE     = 2'd0,
        WBU_WAIT_MEM = 2'd1,
        WBU_WRITE    = 2'd2
    } wbu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/ysyx_23060187_wbu_if.sv
// rtl/ysyx_23060187_wbu_if.sv - WBU upstream, memory-return and register-file signal bundle
// Ports: none; slave modport is the WBU view, master modport the driver/observer view.
interface ysyx_23060187_wbu_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_rd;
    logic                  in_rf_wen;
    logic                  in_is_load;
    logic [2:0]            in_funct3;
    logic [1:0]            in_addr_lo;
    logic [DATA_WIDTH-1:0] in_result;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic                  commit;
    logic                  err;

    modport slave (
        input  in_valid, in_rd, in_rf_wen, in_is_load, in_funct3, in_addr_lo, in_result,
        input  mem_rvalid, mem_rdata,
        output in_ready, rf_wen, rf_waddr, rf_wdata, commit, err
    );

    modport master (
        output in_valid, in_rd, in_rf_wen, in_is_load, in_funct3, in_addr_lo, in_result,
        output mem_rvalid, mem_rdata,
        input  in_ready, rf_wen, rf_waddr, rf_wdata, commit, err
    );

endinterface

// File: rtl/ysyx_23060187_load_ext.sv
// rtl/ysyx_23060187_load_ext.sv - combinational load byte/half/word select and extension
// Ports: funct3_i/addr_lo_i select the lane, rdata_i is the aligned word,
//        data_o is the extended result, fault_o flags illegal codes or misalignment.
module ysyx_23060187_load_ext
    import ysyx_23060187_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            addr_lo_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  fault_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        data_o  = '0;
        fault_o = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_LH: begin
                data_o  = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
                fault_o = addr_lo_i[0];
            end
            F3_LHU: begin
                data_o  = {{(DATA_WIDTH-16){1'b0}}, half_sel};
                fault_o = addr_lo_i[0];
            end
            F3_LW: begin
                data_o  = rdata_i;
                fault_o = (addr_lo_i != 2'b00);
            end
            default: fault_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_23060187_wbu.sv
// rtl/ysyx_23060187_wbu.sv - write-back unit: retires instructions into the register file
// Ports: clk, rst (async, active-high); bus (slave modport) carries the upstream
//        in_* handshake, mem_rvalid/mem_rdata load return, and registered rf_*,
//        commit and sticky err outputs.
module ysyx_23060187_wbu
    import ysyx_23060187_pkg::*;
#(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic               clk,
    input logic               rst,
    ysyx_23060187_wbu_if.slave bus
);

    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    wbu_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wen_flag_q, wen_flag_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic                  commit_q, commit_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] ext_data;
    logic                  ext_fault;

    ysyx_23060187_load_ext #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_ext (
        .funct3_i (funct3_q),
        .addr_lo_i(addr_lo_q),
        .rdata_i  (bus.mem_rdata),
        .data_o   (ext_data),
        .fault_o  (ext_fault)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WBU_IDLE;
            cnt_q      <= '0;
            wen_flag_q <= 1'b0;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            commit_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wen_flag_q <= wen_flag_d;
            funct3_q   <= funct3_d;
            addr_lo_q  <= addr_lo_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            commit_q   <= commit_d;
            err_q      <= err_d;
        end
    end

    // rf_wen/commit are computed on the transition into WRITE so they appear
    // registered during the single WRITE cycle and drop on its exit.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wen_flag_d = wen_flag_q;
        funct3_d   = funct3_q;
        addr_lo_d  = addr_lo_q;
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        commit_d   = 1'b0;
        err_d      = err_q;
        case (state_q)
            WBU_IDLE: begin
                if (bus.in_valid) begin
                    rf_waddr_d = bus.in_rd;
                    wen_flag_d = bus.in_rf_wen;
                    funct3_d   = bus.in_funct3;
                    addr_lo_d  = bus.in_addr_lo;
                    cnt_d      = '0;
                    if (bus.in_is_load) begin
                        state_d = WBU_WAIT_MEM;
                    end else begin
                        rf_wdata_d = bus.in_result;
                        rf_wen_d   = bus.in_rf_wen && (bus.in_rd != '0);
                        commit_d   = 1'b1;
                        state_d    = WBU_WRITE;
                    end
                end
            end
            WBU_WAIT_MEM: begin
                // Data arriving in the expiry cycle wins over the timeout.
                if (bus.mem_rvalid) begin
                    rf_wdata_d = ext_data;
                    rf_wen_d   = wen_flag_q && (rf_waddr_q != '0) && !ext_fault;
                    err_d      = err_q | ext_fault;
                    commit_d   = 1'b1;
                    state_d    = WBU_WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d    = 1'b1;
                    commit_d = 1'b1;
                    state_d  = WBU_WRITE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WBU_WRITE: state_d = WBU_IDLE;
            default:   state_d = WBU_IDLE;
        endcase
    end

    assign bus.in_ready = (state_q == WBU_IDLE);
    assign bus.rf_wen   = rf_wen_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.commit   = commit_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_ysyx_23060187_wbu.sv
// tb/tb_ysyx_23060187_wbu.sv - scoreboard testbench for ysyx_23060187_wbu
module tb_ysyx_23060187_wbu;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic err_m;
    exp_t sb[$];

    ysyx_23060187_wbu_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    ysyx_23060187_wbu #(
        .ADDR_WIDTH    (5),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(256)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference load behaviour: shift the addressed lane down, then extend.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] alo,
                                             input logic [31:0] rdata, output logic fault);
        logic [31:0] sh;
        sh    = rdata >> (8 * alo);
        fault = 1'b0;
        case (f3)
            3'b000:  ref_load = {{24{sh[7]}}, sh[7:0]};
            3'b100:  ref_load = {24'h0, sh[7:0]};
            3'b001: begin ref_load = {{16{sh[15]}}, sh[15:0]}; fault = alo[0]; end
            3'b101: begin ref_load = {16'h0, sh[15:0]}; fault = alo[0]; end
            3'b010: begin ref_load = rdata; fault = (alo != 2'b00); end
            default: begin ref_load = 32'h0; fault = 1'b1; end
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rf_wen) chk("wen_has_commit", bus.commit, 1);
            if (bus.commit) begin
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rf_wen", bus.rf_wen, e.wen);
                    if (e.wen) begin
                        chk("rf_waddr", bus.rf_waddr, e.waddr);
                        chk("rf_wdata", bus.rf_wdata, e.wdata);
                    end
                    chk("err", bus.err, e.err);
                end
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 50) chk("ready_timeout", bus.in_ready, 1);
    endtask

    // Presents one instruction; returns 1 time unit after the accepting edge.
    task automatic issue(input logic is_load, input logic [4:0] rd, input logic wen,
                         input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] res);
        exp_t e;
        wait_ready();
        bus.in_valid   = 1'b1;
        bus.in_is_load = is_load;
        bus.in_rd      = rd;
        bus.in_rf_wen  = wen;
        bus.in_funct3  = f3;
        bus.in_addr_lo = alo;
        bus.in_result  = res;
        if (!is_load) begin
            e.wen   = wen && (rd != 0);
            e.waddr = rd;
            e.wdata = res;
            e.err   = err_m;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.in_rd      = 5'($urandom);
        bus.in_rf_wen  = 1'($urandom);
        bus.in_is_load = 1'($urandom);
        bus.in_funct3  = 3'($urandom);
        bus.in_addr_lo = 2'($urandom);
        bus.in_result  = $urandom;
    endtask

    task automatic nonload(input logic [4:0] rd, input logic wen, input logic [31:0] res);
        issue(1'b0, rd, wen, 3'($urandom), 2'($urandom), res);
        chk("nl_latency", bus.commit, 1);
    endtask

    task automatic do_load(input logic [4:0] rd, input logic wen, input logic [2:0] f3,
                           input logic [1:0] alo, input logic [31:0] rdata, input int dly);
        exp_t e;
        logic f;
        issue(1'b1, rd, wen, f3, alo, 32'hDEAD_BEEF);
        repeat (dly) begin
            chk("ld_wait_nocommit", bus.commit, 0);
            @(posedge clk); #1;
        end
        e.wdata = ref_load(f3, alo, rdata, f);
        err_m   = err_m | f;
        e.wen   = wen && (rd != 0) && !f;
        e.waddr = rd;
        e.err   = err_m;
        sb.push_back(e);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
        chk("ld_latency", bus.commit, 1);
    endtask

    initial begin
        exp_t e;
        int   k;
        n_cmp = 0;
        n_bad = 0;
        err_m = 1'b0;
        rst   = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_rd      = '0;
        bus.in_rf_wen  = 1'b0;
        bus.in_is_load = 1'b0;
        bus.in_funct3  = '0;
        bus.in_addr_lo = '0;
        bus.in_result  = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_rf_wen", bus.rf_wen, 0);
        chk("rst_commit", bus.commit, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_waddr", bus.rf_waddr, 0);
        chk("rst_wdata", bus.rf_wdata, 0);

        // Non-load basic latency
        nonload(5'd5, 1'b1, 32'h1234_5678);
        chk("nl_wen", bus.rf_wen, 1);
        @(posedge clk); #1;
        chk("nl_ready_n2", bus.in_ready, 1);
        chk("nl_commit_drop", bus.commit, 0);

        // Load extension cases
        do_load(5'd7, 1'b1, 3'b000, 2'd3, 32'h80FF_0000, 0);
        do_load(5'd7, 1'b1, 3'b100, 2'd3, 32'h80FF_0000, 2);
        do_load(5'd7, 1'b1, 3'b101, 2'd2, 32'h80FF_0000, 1);
        do_load(5'd9, 1'b1, 3'b001, 2'd2, 32'h8001_7FFF, 4);
        do_load(5'd9, 1'b1, 3'b001, 2'd0, 32'h1234_8001, 0);
        do_load(5'd3, 1'b1, 3'b010, 2'd0, 32'hCAFE_F00D, 3);
        do_load(5'd4, 1'b1, 3'b000, 2'd1, 32'h0000_7F00, 0);
        do_load(5'd0, 1'b1, 3'b010, 2'd0, 32'h5555_AAAA, 1);
        do_load(5'd6, 1'b0, 3'b100, 2'd0, 32'h0000_00F0, 1);

        // rd=0 and wen=0 non-loads, then a few random ones
        nonload(5'd0, 1'b1, 32'hFFFF_FFFF);
        chk("rd0_no_wen", bus.rf_wen, 0);
        nonload(5'd12, 1'b0, 32'h0BAD_0BAD);
        for (int i = 0; i < 6; i++) nonload(5'($urandom_range(1, 31)), 1'b1, $urandom);

        // mem_rvalid while idle is ignored (monitor flags any stray commit)
        wait_ready();
        bus.mem_rvalid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
        chk("stray_rvalid_ready", bus.in_ready, 1);

        // Data arriving in the 256th WAIT_MEM cycle still writes normally
        do_load(5'd10, 1'b1, 3'b010, 2'd0, 32'h0F0F_0F0F, 255);
        chk("last_cycle_no_err", bus.err, 0);

        // Reset mid-WAIT_MEM abandons the load
        issue(1'b1, 5'd11, 1'b1, 3'b010, 2'd0, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_rf_wen", bus.rf_wen, 0);
        chk("midrst_commit", bus.commit, 0);
        chk("midrst_ready", bus.in_ready, 1);
        chk("midrst_waddr", bus.rf_waddr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h7777_7777;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        chk("midrst_no_commit", bus.commit, 0);

        // Timeout: no data for 256 cycles
        issue(1'b1, 5'd13, 1'b1, 3'b010, 2'd0, 32'h0);
        err_m   = 1'b1;
        e.wen   = 1'b0;
        e.waddr = 5'd13;
        e.wdata = 32'h0;
        e.err   = 1'b1;
        sb.push_back(e);
        k = 0;
        while (k < 400 && !bus.commit) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_latency", k, 257);
        @(posedge clk); #1;
        chk("timeout_ready", bus.in_ready, 1);

        // Reset clears err, then a misaligned LH faults and err stays sticky
        rst = 1'b1;
        #1;
        chk("rst_clears_err", bus.err, 0);
        @(posedge clk); #1;
        rst   = 1'b0;
        err_m = 1'b0;
        do_load(5'd8, 1'b1, 3'b001, 2'd1, 32'h1234_5678, 0);
        chk("lh_mis_wen", bus.rf_wen, 0);
        nonload(5'd14, 1'b1, 32'hA5A5_5A5A);
        do_load(5'd15, 1'b1, 3'b011, 2'd0, 32'h1111_1111, 1);
        do_load(5'd16, 1'b1, 3'b010, 2'd2, 32'h2222_2222, 0);
        nonload(5'd17, 1'b1, 32'h0000_0001);
        @(posedge clk); #1;
        chk("err_sticky", bus.err, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
